// File: rtl/cpu_pkg.sv
// Shared front-end definitions: datapath width, fetch FSM states and the NOP encoding.
// Pure declarations, no logic.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IF_RUN,
    IF_FLUSH
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage, so data is visible the cycle after push.
// Push while full without a simultaneous pop is dropped; flush beats push and pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign do_pop     = pop_i & (count_q != '0);
  assign do_push    = push_i & (~full | do_pop);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ifetch_buf.sv
// In-order instruction fetch: requests at pc, tags responses with their address, queues them for decode (rvalid->ir_valid 1 cycle).
// Requests stop once buffered + in-flight reaches DEPTH; a redirect flushes the queue and silently drops stale responses.
module ifetch_buf #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ir_valid,
  output logic [XLEN-1:0] ir_data,
  output logic [XLEN-1:0] ir_pc,
  input  logic            ir_ready
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_e     state_q;
  logic [CW-1:0]     discard_q;
  logic [CW-1:0]     discard_d;
  logic [CW-1:0]     buf_cnt;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     inflight;
  logic [XLEN-1:0]   head_addr;
  logic [2*XLEN-1:0] head_ent;
  logic              run;
  logic              rsp_take;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_full;

  assign run       = (state_q == IF_RUN);
  assign imem_req  = run & ~redirect & ~rst &
                     (({1'b0, buf_cnt} + {1'b0, out_cnt}) < (CW+1)'(DEPTH));
  assign imem_addr = pc;
  assign pc_en     = imem_req & imem_gnt;

  assign rsp_take  = run & imem_rvalid;
  assign buf_push  = rsp_take & ~redirect;
  assign buf_pop   = ir_valid & ir_ready;
  assign buf_full  = (buf_cnt == CW'(DEPTH));

  assign ir_valid  = (buf_cnt != '0) & ~rst;
  assign ir_data   = ir_valid ? head_ent[XLEN-1:0]      : '0;
  assign ir_pc     = ir_valid ? head_ent[2*XLEN-1:XLEN] : '0;

  // Only one of out_cnt / discard_q is ever non-zero, so their sum is the true in-flight count.
  assign inflight  = out_cnt + discard_q;
  assign discard_d = (imem_rvalid && inflight != '0) ? inflight - CW'(1) : inflight;

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_addr_q (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (pc_en),
    .push_dat_i (pc),
    .pop_i      (rsp_take),
    .head_dat_o (head_addr),
    .count_o    (out_cnt)
  );

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (buf_push),
    .push_dat_i ({head_addr, imem_rdata}),
    .pop_i      (buf_pop),
    .head_dat_o (head_ent),
    .count_o    (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IF_RUN;
      discard_q <= '0;
    end else if (redirect) begin
      discard_q <= discard_d;
      state_q   <= (discard_d != '0) ? IF_FLUSH : IF_RUN;
    end else if (!run && imem_rvalid) begin
      discard_q <= discard_q - CW'(1);
      if (discard_q == CW'(1)) state_q <= IF_RUN;
    end
  end

  a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf with a PC counter and an in-order, fixed-latency instruction memory around it.
// Memory returns addr ^ 0xDEAD0000 as the instruction word.
module tb_ifetch_buf;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc;
  logic            pc_en;
  logic            redirect;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            ir_valid;
  logic [XLEN-1:0] ir_data;
  logic [XLEN-1:0] ir_pc;
  logic            ir_ready;

  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pend_addr[$];
  int              pend_due[$];
  int              cyc_n = 0;
  int              lat   = 1;
  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  ifetch_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  task automatic chk_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge after checks: samples this cycle, then advances PC counter and memory past the edge.
  task automatic step();
    logic            took;
    logic            rv;
    logic            en;
    logic            rd;
    logic            rs;
    logic [XLEN-1:0] a;
    took = imem_req & imem_gnt;
    a    = imem_addr;
    rv   = imem_rvalid;
    en   = pc_en;
    rd   = redirect;
    rs   = rst;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rs) begin
      pend_addr.delete();
      pend_due.delete();
      pc = '0;
    end else begin
      if (rv && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (took) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc_n - 1 + lat);
      end
      if (rd)      pc = redir_tgt;
      else if (en) pc = pc + 32'd4;
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc_n) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr[0] ^ 32'hDEAD_0000;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic drain();
    imem_gnt = 1'b0;
    ir_ready = 1'b1;
    repeat (10) tick();
  endtask

  task automatic redir(input string tag, input logic [XLEN-1:0] tgt);
    redirect  = 1'b1;
    redir_tgt = tgt;
    @(negedge clk);
    chk_eq(tag, imem_req, 1'b0);
    step();
    redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc = '0; redirect = 1'b0; redir_tgt = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; ir_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_eq("rst_req",    imem_req, 1'b0);
      chk_eq("rst_pc_en",  pc_en,    1'b0);
      chk_eq("rst_valid",  ir_valid, 1'b0);
      chk_eq("rst_data",   ir_data,  32'h0);
      chk_eq("rst_ir_pc",  ir_pc,    32'h0);
      step();
    end
    rst = 1'b0;

    // Full-rate streaming from pc 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq("stream_pc_en", pc_en,     1'b1);
      chk_eq("stream_addr",  imem_addr, XLEN'(4 * i));
      if (i == 1) chk_eq("stream_no_bypass", ir_valid, 1'b0);
      if (i >= 2) begin
        chk_eq("stream_valid", ir_valid, 1'b1);
        chk_eq("stream_ir_pc", ir_pc,    XLEN'(4 * (i - 2)));
        chk_eq("stream_data",  ir_data,  XLEN'(4 * (i - 2)) ^ 32'hDEAD_0000);
      end
      step();
    end

    // Decode stalls for 5 cycles with entry 0x10 at the head.
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("bp_ir_pc", ir_pc,    32'h10);
      chk_eq("bp_data",  ir_data,  32'hDEAD_0010);
      chk_eq("bp_valid", ir_valid, 1'b1);
      chk_eq("bp_req",   imem_req, (i < 2) ? 1'b1 : 1'b0);
      step();
    end
    ir_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("bp_rel_ir_pc", ir_pc, XLEN'(32'h10 + 4 * i));
      if (i == 0) chk_eq("bp_rel_req0", imem_req, 1'b0);
      if (i == 1) begin
        chk_eq("bp_rel_req1",  imem_req,  1'b1);
        chk_eq("bp_rel_addr1", imem_addr, 32'h20);
      end
      step();
    end

    // Redirect with nothing in flight: no flush, fetch at target next cycle.
    drain();
    imem_gnt = 1'b1;
    redir("r0_req_blocked", 32'h200);
    @(negedge clk);
    chk_eq("r0_req",   imem_req,  1'b1);
    chk_eq("r0_addr",  imem_addr, 32'h200);
    chk_eq("r0_pc_en", pc_en,     1'b1);
    chk_eq("r0_valid", ir_valid,  1'b0);
    step();
    @(negedge clk);
    chk_eq("r0_lat_valid", ir_valid, 1'b0);
    step();
    @(negedge clk);
    chk_eq("r0_out_valid", ir_valid, 1'b1);
    chk_eq("r0_out_pc",    ir_pc,    32'h200);
    chk_eq("r0_out_data",  ir_data,  32'hDEAD_0200);
    step();

    // Redirect with two requests in flight (latency 3): both stale responses dropped.
    drain();
    lat = 3;
    imem_gnt = 1'b1;
    redir("r2_setup_req", 32'h300);
    @(negedge clk);
    chk_eq("r2_s0_addr", imem_addr, 32'h300);
    chk_eq("r2_s0_en",   pc_en,     1'b1);
    step();
    @(negedge clk);
    chk_eq("r2_s1_addr", imem_addr, 32'h304);
    chk_eq("r2_s1_en",   pc_en,     1'b1);
    step();
    redir("r2_s2_req", 32'h100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_eq("r2_flush_req",   imem_req, 1'b0);
      chk_eq("r2_flush_valid", ir_valid, 1'b0);
      step();
    end
    @(negedge clk);
    chk_eq("r2_resume_req",  imem_req,  1'b1);
    chk_eq("r2_resume_addr", imem_addr, 32'h100);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("r2_no_stale", ir_valid, 1'b0);
      step();
    end
    @(negedge clk);
    chk_eq("r2_out_valid", ir_valid, 1'b1);
    chk_eq("r2_out_pc",    ir_pc,    32'h100);
    chk_eq("r2_out_data",  ir_data,  32'hDEAD_0100);
    step();

    // Grant withheld for 3 cycles.
    drain();
    lat = 1;
    redir("gs_setup_req", 32'h400);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("gs_req",   imem_req,  1'b1);
      chk_eq("gs_pc_en", pc_en,     1'b0);
      chk_eq("gs_addr",  imem_addr, 32'h400);
      step();
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    chk_eq("gs_go_en",   pc_en,     1'b1);
    chk_eq("gs_go_addr", imem_addr, 32'h400);
    step();
    @(negedge clk);
    chk_eq("gs_next_addr", imem_addr, 32'h404);
    step();
    @(negedge clk);
    chk_eq("gs_out0_pc", ir_pc, 32'h400);
    step();
    @(negedge clk);
    chk_eq("gs_out1_pc",    ir_pc,    32'h404);
    chk_eq("gs_out1_valid", ir_valid, 1'b1);
    step();

    // Reset with one request in flight.
    rst = 1'b1;
    @(negedge clk);
    chk_eq("mr_req",   imem_req, 1'b0);
    chk_eq("mr_pc_en", pc_en,    1'b0);
    step();
    @(negedge clk);
    chk_eq("mr1_req",   imem_req, 1'b0);
    chk_eq("mr1_pc_en", pc_en,    1'b0);
    chk_eq("mr1_valid", ir_valid, 1'b0);
    chk_eq("mr1_data",  ir_data,  32'h0);
    chk_eq("mr1_ir_pc", ir_pc,    32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_eq("mr_fetch_req",  imem_req,  1'b1);
    chk_eq("mr_fetch_addr", imem_addr, 32'h0);
    step();
    @(negedge clk);
    chk_eq("mr_lat_valid", ir_valid, 1'b0);
    step();
    @(negedge clk);
    chk_eq("mr_out_valid", ir_valid, 1'b1);
    chk_eq("mr_out_pc",    ir_pc,    32'h0);
    chk_eq("mr_out_data",  ir_data,  32'hDEAD_0000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 Parameter DEPTH, default 2, meaning instruction buffer entries and maximum requests in flight (power of 2, >=2).
REQ-002 Parameter XLEN, default 32, meaning address and instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  XLEN  current PC from the PC counter.
REQ-006 pc_en  output  1  advance enable to the PC counter; PC counter steps on next edge when high.
REQ-007 redirect  input  1  PC mux selected a non-sequential source this cycle; flush.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  XLEN  request address.
REQ-010 imem_gnt  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid; responses in request order, >=1 cycle after grant.
REQ-012 imem_rdata  input  XLEN  instruction word.
REQ-013 ir_valid  output  1  instruction available to decode.
REQ-014 ir_data  output  XLEN  instruction word.
REQ-015 ir_pc  output  XLEN  address of ir_data.
REQ-016 ir_ready  input  1  decode consumes entry when ir_valid&ir_ready.

Function
REQ-017 imem_req SHALL be high iff state RUN, redirect low, rst low, and (fifo_count + outstanding) < DEPTH; imem_addr = pc combinationally.
REQ-018 pc_en SHALL equal imem_req & imem_gnt (same cycle); no other source.
REQ-019 Each granted request SHALL push its address into an in-flight address queue and increment outstanding (0..DEPTH).
REQ-020 In RUN, imem_rvalid SHALL decrement outstanding and push {in-flight address, imem_rdata} into the buffer; ir_valid rises the cycle after rvalid (1-cycle latency, no bypass).
REQ-021 Grant and rvalid in the same cycle SHALL leave outstanding unchanged; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-022 Buffer SHALL never overflow by construction of REQ-017; rvalid while full is a protocol error (assertion), data dropped.
REQ-023 ir_valid/ir_data/ir_pc SHALL be held stable while ir_valid & !ir_ready.
REQ-024 FSM states RUN, FLUSH. RUN->FLUSH on redirect with outstanding (after this cycle's rvalid) > 0; RUN->RUN on redirect with none outstanding.
REQ-025 On redirect (any state): buffer and in-flight address queue cleared next edge; ir_valid low next cycle; discard counter loaded with remaining outstanding.
REQ-026 In FLUSH: no requests; each rvalid decrements discard counter and is dropped; FLUSH->RUN when counter reaches 0 (last rvalid cycle); requests resume the cycle after.
REQ-027 Pointers and counters SHALL wrap modulo DEPTH; fifo_count saturates at DEPTH, never wraps to 0.

Reset
REQ-028 While rst high: state RUN, fifo_count/outstanding/discard 0, pointers 0, imem_req 0, pc_en 0, ir_valid 0, ir_data 0, ir_pc 0.
REQ-029 Reset mid-operation SHALL abandon all in-flight requests; memory side is reset by the same rst.

Structure
REQ-030 Shared package cpu_pkg SHALL hold XLEN, the ifetch state enumeration, and the NOP encoding constant.
REQ-031 Buffer SHALL be one sub-module ifetch_fifo (synchronous FIFO, push/pop/flush/count); in-flight address queue may reuse it.

Verification
REQ-032 Streaming: gnt always 1, rvalid 1 cycle after gnt, ir_ready 1, pc from 0x0 step 4 -> ir_pc 0x0,0x4,0x8 consecutive cycles, pc_en high every cycle.
REQ-033 Backpressure: ir_ready 0 for 5 cycles -> imem_req drops after DEPTH accepts, ir_data stable, no loss on release.
REQ-034 Redirect with 2 outstanding to pc 0x100 -> two stale rvalids dropped, first ir_pc after = 0x100.
REQ-035 Redirect with 0 outstanding and simultaneous ir_ready -> no FLUSH, next request same following cycle at new pc.
REQ-036 Grant stalls (gnt 0 for 3 cycles) -> pc_en 0, imem_addr held, no duplicate pushes.
REQ-037 rst asserted with 1 outstanding -> all outputs 0 next cycle; post-reset fetch from reset pc correct.
